// File: rtl/wb_xform_pkg.sv
// wb_xform_pkg: transform mode encodings and register index map shared by the
// register bank and its per-channel transform units.
package wb_xform_pkg;
    typedef enum logic [1:0] {MODE_PASS, MODE_INVERT, MODE_INCR, MODE_BSWAP} mode_t;
    localparam logic [5:0] IDX_IN_BASE  = 6'd0;
    localparam logic [5:0] IDX_OUT_BASE = 6'd16;
    localparam logic [5:0] IDX_CTRL     = 6'd60;
    localparam logic [5:0] IDX_STATUS   = 6'd61;
    localparam logic [5:0] IDX_MASK     = 6'd62;
endpackage

// File: rtl/wb_xform_unit.sv
// wb_xform_unit: two-stage transform pipe; stage 1 captures data and mode at
// launch, stage 2 holds the transformed result alongside its done pulse.
module wb_xform_unit import wb_xform_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              launch,
    input  mode_t             mode,
    input  logic [DATA_W-1:0] data,
    output logic              done,
    output logic [DATA_W-1:0] result
);
    logic v1;
    mode_t m1;
    logic [DATA_W-1:0] d1, x;
    always_comb begin
        x = m1 == MODE_INVERT ? ~d1 : m1 == MODE_INCR ? d1 + DATA_W'(1) : d1;
        if (m1 == MODE_BSWAP)
            for (int b = 0; b < DATA_W / 8; b++) x[8*b +: 8] = d1[DATA_W-8-8*b +: 8];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            m1 <= MODE_PASS;
            d1 <= '0;
            done <= 1'b0;
            result <= '0;
        end else begin
            v1 <= launch;
            if (launch) begin
                m1 <= mode;
                d1 <= data;
            end
            done <= v1;
            if (v1) result <= x;
        end
    end
endmodule

// File: rtl/wb_xform_regbank.sv
// wb_xform_regbank: Wishbone register bank of NUM_CH input/derived-output pairs.
// Define WB_XFORM_IRQ_EN to implement MASK and the channel-done interrupt.
module wb_xform_regbank import wb_xform_pkg::*; #(
    parameter int DATA_W   = 32,
    parameter int NUM_CH   = 4,
    parameter int BASE_NIB = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [2:0]  irq
);
    localparam int NB = DATA_W / 8;
    logic sel, acc, wr;
    logic [5:0] idx;
    logic [31:0] rdata;
    logic [NUM_CH-1:0][DATA_W-1:0] in_r, out_r, merged, res;
    logic [NUM_CH-1:0] launch, done, status;
    logic [2*NUM_CH-1:0] ctrl;
    logic unused_ok;
    assign sel = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == 4'(BASE_NIB));
    assign acc = sel & ~wbs_ack_o;
    assign wr = acc & wbs_we_i;
    assign idx = wbs_adr_i[7:2];
    assign unused_ok = ^{wbs_adr_i[27:8], wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};
`ifdef WB_XFORM_IRQ_EN
    logic [NUM_CH-1:0] mask;
    logic irq_r;
    assign irq = {2'b00, irq_r};
`else
    assign irq = 3'b000;
`endif
    always_comb begin
        merged = in_r;
        launch = '0;
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int b = 0; b < NB; b++)
                merged[i][8*b +: 8] = wbs_sel_i[b] ? wbs_dat_i[8*b +: 8] : in_r[i][8*b +: 8];
            launch[i] = wr && idx == IDX_IN_BASE + 6'(i);
            if (idx == IDX_IN_BASE + 6'(i)) rdata = 32'(in_r[i]);
            if (idx == IDX_OUT_BASE + 6'(i)) rdata = 32'(out_r[i]);
        end
        if (idx == IDX_CTRL) rdata = 32'(ctrl);
        if (idx == IDX_STATUS) rdata = 32'(status);
`ifdef WB_XFORM_IRQ_EN
        if (idx == IDX_MASK) rdata = 32'(mask);
`endif
    end
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        wb_xform_unit #(.DATA_W(DATA_W)) u_unit (
            .clk(wb_clk_i),
            .rst(wb_rst_i),
            .launch(launch[g]),
            .mode(mode_t'(ctrl[2*g +: 2])),
            .data(merged[g]),
            .done(done[g]),
            .result(res[g])
        );
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            in_r <= '0;
            out_r <= '0;
            ctrl <= '0;
            status <= '0;
`ifdef WB_XFORM_IRQ_EN
            mask <= '0;
            irq_r <= 1'b0;
`endif
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= acc ? rdata : '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (launch[i]) in_r[i] <= merged[i];
                if (done[i]) out_r[i] <= res[i];
            end
            if (wr && idx == IDX_CTRL) ctrl <= wbs_dat_i[2*NUM_CH-1:0];
            // a done arriving with a W1C of the same bit keeps the bit set
            status <= (status & ~((wr && idx == IDX_STATUS) ? wbs_dat_i[NUM_CH-1:0] : '0)) | done;
`ifdef WB_XFORM_IRQ_EN
            if (wr && idx == IDX_MASK) mask <= wbs_dat_i[NUM_CH-1:0];
            irq_r <= |(status & mask);
`endif
        end
    end
endmodule

// File: tb/tb_wb_xform_regbank.sv
// tb_wb_xform_regbank: directed Wishbone transactions; expected read data is
// queued at issue and compared by an independent ack monitor.
module tb_wb_xform_regbank;
    logic clk = 1'b0, rst = 1'b1;
    logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0] sel = 4'h0;
    logic [31:0] dat = '0, adr = '0;
    logic ack;
    logic [31:0] rdat;
    logic [2:0] irq;
    typedef struct {logic chk; logic [31:0] exp; string name;} exp_t;
    exp_t q[$];
    exp_t e;
    int n_chk = 0, n_fail = 0;
`ifdef WB_XFORM_IRQ_EN
    localparam logic [31:0] IRQ_ON = 32'd1, MASK_RB = 32'h2;
`else
    localparam logic [31:0] IRQ_ON = 32'd0, MASK_RB = 32'h0;
`endif

    always #5 clk = ~clk;

    wb_xform_regbank dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(rdat), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ack) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with no transaction outstanding");
            end else begin
                e = q.pop_front();
                if (e.chk) check(e.name, rdat, e.exp);
            end
        end
    end

    // called at a negedge; holds stb one extra cycle after ack to probe for a double ack
    task automatic xfer(input logic w, input logic [5:0] idx, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp, input string name);
        int n = 0;
        q.push_back('{!w, exp, name});
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat = d;
        adr = {4'h3, 20'h0, idx, 2'b00};
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        check({name, "_lat"}, n, 1);
        @(negedge clk);
        check({name, "_once"}, {31'b0, ack}, 0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [5:0] idx, input logic [31:0] d, input logic [3:0] s, input string name);
        xfer(1'b1, idx, d, s, 32'h0, name);
    endtask

    task automatic rd(input logic [5:0] idx, input logic [31:0] exp, input string name);
        xfer(1'b0, idx, 32'h0, 4'hF, exp, name);
    endtask

    task automatic unsel(input logic c, input logic [3:0] nib, input string name);
        int n = 0;
        cyc = c; stb = 1'b1; we = 1'b1; sel = 4'hF; dat = 32'hCAFEF00D;
        adr = {nib, 20'h0, 6'd0, 2'b00};
        repeat (3) begin
            @(negedge clk);
            n += int'(ack);
        end
        check(name, n, 0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ack", {31'b0, ack}, 0);
        check("rst_dat", rdat, 0);
        check("rst_irq", {29'b0, irq}, 0);
        rst = 1'b0;
        @(negedge clk);
        rd(6'd0, 32'h0, "rst_in0");
        rd(6'd16, 32'h0, "rst_out0");
        rd(6'd60, 32'h0, "rst_ctrl");
        rd(6'd61, 32'h0, "rst_status");
        // PASS, and OUT lands two cycles after the write ack
        wr(6'd1, 32'hDEADBEEF, 4'hF, "w_in1");
        rd(6'd17, 32'h0, "out1_early");
        rd(6'd61, 32'h2, "status_ch1");
        rd(6'd17, 32'hDEADBEEF, "out1_pass");
        wr(6'd60, 32'h1, 4'hF, "w_ctrl_inv");
        wr(6'd0, 32'h0000FFFF, 4'hF, "w_in0_inv");
        rd(6'd0, 32'h0000FFFF, "in0_inv");
        rd(6'd16, 32'hFFFF0000, "out0_inv");
        wr(6'd60, 32'h2, 4'hF, "w_ctrl_incr");
        rd(6'd16, 32'hFFFF0000, "out0_no_recompute");
        wr(6'd0, 32'hFFFFFFFF, 4'hF, "w_in0_incr");
        rd(6'd0, 32'hFFFFFFFF, "in0_incr");
        rd(6'd16, 32'h0, "out0_incr_wrap");
        wr(6'd2, 32'hAABBCCDD, 4'hF, "w_in2_prior");
        wr(6'd60, 32'h30, 4'hF, "w_ctrl_bswap");
        wr(6'd2, 32'h11223344, 4'h3, "w_in2_lanes");
        rd(6'd2, 32'hAABB3344, "in2_merge");
        rd(6'd18, 32'h4433BBAA, "out2_bswap");
        rd(6'd60, 32'h30, "ctrl_rb");
        wr(6'd61, 32'hF, 4'hF, "w1c_all");
        rd(6'd61, 32'h0, "status_cleared");
        // the STATUS write lands on the same edge as the ch0 done
        wr(6'd0, 32'h5, 4'hF, "w_in0_race");
        wr(6'd61, 32'h1, 4'hF, "w1c_race");
        rd(6'd61, 32'h1, "status_set_wins");
        wr(6'd61, 32'h1, 4'hF, "w1c_ch0");
        rd(6'd61, 32'h0, "status_ch0_clr");
        rd(6'd16, 32'h5, "out0_race");
        wr(6'd62, 32'h2, 4'hF, "w_mask");
        wr(6'd1, 32'h1, 4'hF, "w_in1_irq");
        rd(6'd62, MASK_RB, "mask_rb");
        rd(6'd61, 32'h2, "status_irq");
        check("irq_set", {29'b0, irq}, IRQ_ON);
        wr(6'd61, 32'h2, 4'hF, "w1c_ch1");
        rd(6'd61, 32'h0, "status_ch1_clr");
        check("irq_clr", {29'b0, irq}, 0);
        wr(6'd40, 32'h12345678, 4'hF, "w_bad");
        rd(6'd40, 32'h0, "rd_bad");
        wr(6'd17, 32'hFFFFFFFF, 4'hF, "w_ro_out1");
        rd(6'd17, 32'h1, "out1_ro");
        wr(6'd3, 32'h1, 4'hF, "w_in3_a");
        wr(6'd3, 32'h2, 4'hF, "w_in3_b");
        rd(6'd3, 32'h2, "in3_b2b");
        rd(6'd19, 32'h2, "out3_last_wins");
        unsel(1'b1, 4'h4, "unsel_nib");
        unsel(1'b0, 4'h3, "unsel_cyc");
        rd(6'd0, 32'h5, "in0_untouched");
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
